parity_frame_checker: RTL

Serial, parametrised successor to the team's 4-bit combinational parity checker. Accepts frames of DATA_W data bits plus one trailing parity bit, one bit per accepted cycle, and checks even or odd parity per frame. Reports a per-frame result pulse with the recovered data word, and keeps saturating frame and error statistics. Sits between a serial receive front-end and the status/register logic.

---
 rtl/parity_pkg.sv | 6 +
 rtl/sat_counter.sv | 18 +
 rtl/parity_frame_checker.sv | 97 +++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and parity mode constants for the frame checker
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that still applies the same-cycle increment
//   clk, rst_n : clock, async active-low reset
//   clr        : load 0 (then add inc)
//   inc        : count one event
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? W'(inc) : count + W'(inc & ~&count);
endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: serial DATA_W-bit + parity frame checker with saturating frame/error statistics
//   clk, rst_n                 : clock, async active-low reset
//   bit_in, bit_valid, sof     : serial bit (data MSB first, parity last), qualifier, start of frame
//   odd_mode                   : parity mode, sampled with the sof bit
//   clr_stat                   : clears frame_cnt, err_cnt, sticky_err (same-cycle event still counts)
//   busy                       : frame in progress
//   data_out                   : data word of last completed frame
//   frame_done/err/abort       : one-cycle result pulses
//   frame_cnt, err_cnt         : saturating statistics
//   sticky_err                 : any error since clear
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  input  logic              odd_mode,
  input  logic              clr_stat,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              frame_err,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sticky_err
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state, state_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] sh, sh_n, data_n;
  logic acc, acc_n, mode, mode_n, done_n, err_n, abort_n;
  // sof always wins: a restart in DATA/PARITY drops the partial frame and begins a new one
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    mode_n  = mode;
    sh_n    = sh;
    data_n  = data_out;
    done_n  = 1'b0;
    err_n   = 1'b0;
    abort_n = 1'b0;
    if (bit_valid && sof) begin
      abort_n = state != IDLE;
      state_n = (DATA_W == 1) ? PARITY : DATA;
      cnt_n   = BW'(1);
      acc_n   = bit_in;
      sh_n    = DATA_W'(bit_in);
      mode_n  = odd_mode;
    end else if (bit_valid && state == DATA) begin
      state_n = (cnt == BW'(DATA_W - 1)) ? PARITY : DATA;
      cnt_n   = cnt + BW'(1);
      acc_n   = acc ^ bit_in;
      sh_n    = (sh << 1) | DATA_W'(bit_in);
    end else if (bit_valid && state == PARITY) begin
      state_n = IDLE;
      cnt_n   = '0;
      acc_n   = 1'b0;
      data_n  = sh;
      done_n  = 1'b1;
      err_n   = (acc ^ bit_in) != mode;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= 1'b0;
      mode        <= PAR_EVEN;
      sh          <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_abort <= 1'b0;
      sticky_err  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      mode        <= mode_n;
      sh          <= sh_n;
      data_out    <= data_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
      frame_abort <= abort_n;
      sticky_err  <= (sticky_err & ~clr_stat) | err_n;
    end
  assign busy = state != IDLE;
  sat_counter #(.W(CNT_W)) u_frame_cnt (.clk(clk), .rst_n(rst_n), .clr(clr_stat), .inc(done_n), .count(frame_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt (.clk(clk), .rst_n(rst_n), .clr(clr_stat), .inc(err_n), .count(err_cnt));
endmodule
